// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, the imem request/ack handshake and the IF/ID register.
// Handles hazard freeze and EXE branch redirects. A request that is still pending when a redirect arrives is drained.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        freez,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] hold_buf_reg;
  logic [31:0] target_reg;
  logic [31:0] pc_next;
  logic [31:0] br_target;

  assign pc_next   = pc_reg + STEP;
  assign br_target = branch_addr & ~32'h3;

  // In DRAIN pc_reg is left untouched, so the orphaned request keeps its address.
  assign imem_req  = (state_reg == REQ) || (state_reg == DRAIN);
  assign imem_addr = pc_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      hold_buf_reg <= '0;
      target_reg   <= '0;
      instruction  <= '0;
      PC           <= '0;
      valid        <= 1'b0;
    end else if (branch_taken) begin
      instruction <= '0;
      valid       <= 1'b0;
      case (state_reg)
        REQ: begin
          if (imem_ack) begin
            pc_reg    <= br_target;
          end else begin
            target_reg <= br_target;
            state_reg  <= DRAIN;
          end
        end
        DRAIN: target_reg <= br_target;
        default: begin
          pc_reg    <= br_target;
          state_reg <= REQ;
        end
      endcase
    end else begin
      // Bubble unless a load below overrides it; a freeze keeps IF/ID as is.
      if (!freez) begin
        instruction <= '0;
        valid       <= 1'b0;
      end
      case (state_reg)
        IDLE: state_reg <= REQ;
        REQ: begin
          if (imem_ack) begin
            if (!freez) begin
              instruction <= imem_rdata;
              PC          <= pc_next;
              valid       <= 1'b1;
              pc_reg      <= pc_next;
            end else begin
              hold_buf_reg <= imem_rdata;
              state_reg    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!freez) begin
            instruction <= hold_buf_reg;
            PC          <= pc_next;
            valid       <= 1'b1;
            pc_reg      <= pc_next;
            state_reg   <= REQ;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc_reg    <= target_reg;
            state_reg <= REQ;
          end
        end
      endcase
    end
  end

endmodule
